// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing defaults, axis-total helper and the scan coordinate type.
package vga_timing_pkg;

    localparam int unsigned DEF_H_VISIBLE = 640;
    localparam int unsigned DEF_H_FP      = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BP      = 48;
    localparam int unsigned DEF_V_VISIBLE = 480;
    localparam int unsigned DEF_V_FP      = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BP      = 33;

    localparam int unsigned COORD_W   = 10;
    localparam int unsigned MAX_TOTAL = 1 << COORD_W;

    typedef logic [COORD_W-1:0] coord_t;
    // One extra bit so window bounds equal to MAX_TOTAL stay representable.
    typedef logic [COORD_W:0]   span_t;

    function automatic int unsigned axis_total(input int unsigned visible, input int unsigned fp,
                                               input int unsigned sync, input int unsigned bp);
        return visible + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One scan axis: counts 0..TOTAL-1 on each tick, flags wrap, visible region and next-count sync window.
// Latency: count is registered; wrap/visible/sync_nxt are combinational. No backpressure.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned VISIBLE = DEF_H_VISIBLE,
    parameter int unsigned FP      = DEF_H_FP,
    parameter int unsigned SYNC    = DEF_H_SYNC,
    parameter int unsigned BP      = DEF_H_BP
) (
    input  logic               vga_clk,
    input  logic               reset,
    input  logic               tick,
    output logic [COORD_W-1:0] count,
    output logic               wrap,
    output logic               visible,
    output logic               sync_nxt
);

    localparam int unsigned TOTAL = axis_total(VISIBLE, FP, SYNC, BP);

    localparam span_t LAST     = span_t'(TOTAL - 1);
    localparam span_t VIS_END  = span_t'(VISIBLE);
    localparam span_t SYNC_BEG = span_t'(VISIBLE + FP);
    localparam span_t SYNC_END = span_t'(VISIBLE + FP + SYNC);

    coord_t count_nxt;

    always_comb begin
        wrap      = tick && ({1'b0, count} == LAST);
        count_nxt = count;
        if (wrap) begin
            count_nxt = '0;
        end else if (tick) begin
            count_nxt = count + 1'b1;
        end
        visible  = ({1'b0, count} < VIS_END);
        // Evaluated on the next count so the registered sync lines up with the count itself.
        sync_nxt = ({1'b0, count_nxt} >= SYNC_BEG) && ({1'b0, count_nxt} < SYNC_END);
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count_nxt;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA pixel-timing master: DrawX/DrawY counters, registered hs/vs, blank and line/frame pulses; free-running, no backpressure.
// Zero latency vs DrawX; defining VGA_SYNC_DELAY_EN delays hs/vs/blank/frame_start/line_start by one clock.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
    parameter int unsigned H_FP      = DEF_H_FP,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BP      = DEF_H_BP,
    parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
    parameter int unsigned V_FP      = DEF_V_FP,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BP      = DEF_V_BP,
    parameter logic        HS_POL    = 1'b0,
    parameter logic        VS_POL    = 1'b0
) (
    input  logic                vga_clk,
    input  logic                reset,
    output logic                hs,
    output logic                vs,
    output logic                blank,
    output logic [COORD_W-1:0]  DrawX,
    output logic [COORD_W-1:0]  DrawY,
    output logic                frame_start,
    output logic                line_start
);

    localparam int unsigned H_TOTAL = axis_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = axis_total(V_VISIBLE, V_FP, V_SYNC, V_BP);

    generate
        if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_total_check
            $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 10-bit coordinate range");
        end
    endgenerate

    coord_t hc, vc;
    logic   h_wrap, h_vis, h_sync_nxt;
    logic   v_wrap_unused, v_vis, v_sync_nxt;
    logic   hs_q, vs_q;
    logic   h_first, v_first;

    vga_axis_counter #(
        .VISIBLE (H_VISIBLE),
        .FP      (H_FP),
        .SYNC    (H_SYNC),
        .BP      (H_BP)
    ) u_h_axis (
        .vga_clk  (vga_clk),
        .reset    (reset),
        .tick     (1'b1),
        .count    (hc),
        .wrap     (h_wrap),
        .visible  (h_vis),
        .sync_nxt (h_sync_nxt)
    );

    vga_axis_counter #(
        .VISIBLE (V_VISIBLE),
        .FP      (V_FP),
        .SYNC    (V_SYNC),
        .BP      (V_BP)
    ) u_v_axis (
        .vga_clk  (vga_clk),
        .reset    (reset),
        .tick     (h_wrap),
        .count    (vc),
        .wrap     (v_wrap_unused),
        .visible  (v_vis),
        .sync_nxt (v_sync_nxt)
    );

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            hs_q <= ~HS_POL;
            vs_q <= ~VS_POL;
        end else begin
            hs_q <= h_sync_nxt ? HS_POL : ~HS_POL;
            vs_q <= v_sync_nxt ? VS_POL : ~VS_POL;
        end
    end

    assign h_first = (hc == '0);
    assign v_first = (vc == '0);
    assign DrawX   = hc;
    assign DrawY   = vc;

`ifdef VGA_SYNC_DELAY_EN
    logic hs_d, vs_d, blank_d, frame_start_d, line_start_d;

    // Extra stage matches renderers that register colour one clock after DrawX.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            hs_d          <= ~HS_POL;
            vs_d          <= ~VS_POL;
            blank_d       <= 1'b0;
            frame_start_d <= 1'b0;
            line_start_d  <= 1'b0;
        end else begin
            hs_d          <= hs_q;
            vs_d          <= vs_q;
            blank_d       <= h_vis && v_vis;
            frame_start_d <= h_first && v_first;
            line_start_d  <= h_first;
        end
    end

    assign hs          = hs_d;
    assign vs          = vs_d;
    assign blank       = blank_d;
    assign frame_start = frame_start_d;
    assign line_start  = line_start_d;
`else
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign blank       = h_vis && v_vis && !reset;
    assign frame_start = h_first && v_first && !reset;
    assign line_start  = h_first && !reset;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance plus a small active-high, single-clock-hsync instance.
module tb_vga_timing_gen;

    localparam int NCYC = 8000;

    // Small instance geometry: H 8+2+1+3 = 14 clocks, V 6+2+2+3 = 13 lines.
    localparam int S_HV = 8, S_HF = 2, S_HS = 1, S_HB = 3;
    localparam int S_VV = 6, S_VF = 2, S_VS = 2, S_VB = 3;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       blank;
        logic       fs;
        logic       ls;
        logic [9:0] x;
        logic [9:0] y;
    } obs_t;

    logic vga_clk = 1'b0;
    logic reset   = 1'b1;
    always #5 vga_clk = ~vga_clk;

    logic       d_hs, d_vs, d_blank, d_fs, d_ls;
    logic [9:0] d_x, d_y;
    logic       s_hs, s_vs, s_blank, s_fs, s_ls;
    logic [9:0] s_x, s_y;

    vga_timing_gen dut_dflt (
        .vga_clk     (vga_clk),
        .reset       (reset),
        .hs          (d_hs),
        .vs          (d_vs),
        .blank       (d_blank),
        .DrawX       (d_x),
        .DrawY       (d_y),
        .frame_start (d_fs),
        .line_start  (d_ls)
    );

    vga_timing_gen #(
        .H_VISIBLE (S_HV), .H_FP (S_HF), .H_SYNC (S_HS), .H_BP (S_HB),
        .V_VISIBLE (S_VV), .V_FP (S_VF), .V_SYNC (S_VS), .V_BP (S_VB),
        .HS_POL    (1'b1), .VS_POL (1'b1)
    ) dut_small (
        .vga_clk     (vga_clk),
        .reset       (reset),
        .hs          (s_hs),
        .vs          (s_vs),
        .blank       (s_blank),
        .DrawX       (s_x),
        .DrawY       (s_y),
        .frame_start (s_fs),
        .line_start  (s_ls)
    );

    int   total = 0;
    int   bad   = 0;
    bit   started = 1'b0;
    obs_t q_d[$];
    obs_t q_s[$];

    // Reference: position is simply (cycles since release) folded into line/frame lengths.
    function automatic obs_t idle_obs(input logic hp, input logic vp);
        obs_t o;
        o = '0;
        o.hs = ~hp;
        o.vs = ~vp;
        return o;
    endfunction

    function automatic obs_t scan_obs(input int n, input int hv, input int hf, input int hsy, input int hb,
                                      input int vv, input int vf, input int vsy, input int vb,
                                      input logic hp, input logic vp);
        obs_t o;
        int   ht, vt, x, y;
        ht = hv + hf + hsy + hb;
        vt = vv + vf + vsy + vb;
        x  = n % ht;
        y  = (n / ht) % vt;
        o.x     = 10'(x);
        o.y     = 10'(y);
        o.hs    = (x >= hv + hf && x < hv + hf + hsy) ? hp : ~hp;
        o.vs    = (y >= vv + vf && y < vv + vf + vsy) ? vp : ~vp;
        o.blank = (x < hv) && (y < vv);
        o.fs    = (x == 0) && (y == 0);
        o.ls    = (x == 0);
        return o;
    endfunction

    function automatic obs_t expect_obs(input bit rst, input int n, input int hv, input int hf, input int hsy,
                                        input int hb, input int vv, input int vf, input int vsy, input int vb,
                                        input logic hp, input logic vp);
        obs_t cur, prev;
        if (rst) return idle_obs(hp, vp);
        cur = scan_obs(n, hv, hf, hsy, hb, vv, vf, vsy, vb, hp, vp);
`ifdef VGA_SYNC_DELAY_EN
        prev = (n == 0) ? idle_obs(hp, vp) : scan_obs(n - 1, hv, hf, hsy, hb, vv, vf, vsy, vb, hp, vp);
        cur.hs    = prev.hs;
        cur.vs    = prev.vs;
        cur.blank = prev.blank;
        cur.fs    = prev.fs;
        cur.ls    = prev.ls;
`else
        prev = cur;
`endif
        return cur;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("hs=%b vs=%b blank=%b fs=%b ls=%b x=%0d y=%0d", o.hs, o.vs, o.blank, o.fs, o.ls, o.x, o.y);
    endfunction

    // Stimulus: drive reset shortly after each edge and queue what each DUT must show this cycle.
    initial begin
        int n         = 0;
        int rst_left  = 0;
        bit directed  = 1'b0;
        bit rst_now;
        for (int c = 0; c < NCYC; c++) begin
            @(posedge vga_clk);
            #2;
            if (c < 3) begin
                rst_now = 1'b1;
            end else if (rst_left > 0) begin
                rst_now  = 1'b1;
                rst_left = rst_left - 1;
            end else if (!directed && n == 8 * 14 + 10) begin
                // Small instance sits at (10,8): hs and vs both active when reset hits.
                rst_now  = 1'b1;
                rst_left = 1;
                directed = 1'b1;
            end else if ($urandom_range(0, 2499) == 0) begin
                rst_now  = 1'b1;
                rst_left = int'($urandom_range(0, 2));
            end else begin
                rst_now = 1'b0;
            end
            reset = rst_now;
            q_d.push_back(expect_obs(rst_now, n, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0));
            q_s.push_back(expect_obs(rst_now, n, S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB, 1'b1, 1'b1));
            n = rst_now ? 0 : n + 1;
            started = 1'b1;
        end
        @(negedge vga_clk);
        #1;
        total++;
        if (q_d.size() != 0 || q_s.size() != 0) begin
            bad++;
            $display("FAIL drain leftover actual dflt=%0d small=%0d required 0", q_d.size(), q_s.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Monitor: every cycle both DUTs present a scan position; compare mid-cycle.
    always @(negedge vga_clk) begin
        obs_t e, a;
        if (started) begin
            total++;
            if (q_d.size() == 0) begin
                bad++;
                $display("FAIL dflt_underflow at %0t actual empty required entry", $time);
            end else begin
                e = q_d.pop_front();
                a = '{hs: d_hs, vs: d_vs, blank: d_blank, fs: d_fs, ls: d_ls, x: d_x, y: d_y};
                if (a !== e) begin
                    bad++;
                    $display("FAIL dflt at %0t actual %s required %s", $time, fmt(a), fmt(e));
                end
            end
            total++;
            if (q_s.size() == 0) begin
                bad++;
                $display("FAIL small_underflow at %0t actual empty required entry", $time);
            end else begin
                e = q_s.pop_front();
                a = '{hs: s_hs, vs: s_vs, blank: s_blank, fs: s_fs, ls: s_ls, x: s_x, y: s_y};
                if (a !== e) begin
                    bad++;
                    $display("FAIL small at %0t actual %s required %s", $time, fmt(a), fmt(e));
                end
            end
        end
    end

endmodule
